// File: rtl/cc_seq_pkg.sv
// cc_seq_pkg: shared widths, FSM state encoding and small helpers for the
// serial compute core (cc_seq).
//   NUM_IN  - operands per packet
//   OP_W    - signed operand / cumulant width
//   CUM_W   - width of the cumulative-average intermediate (2*c + s)
//   PROD_W  - width of the equation product
//   OUT_W   - width of the signed result
package cc_seq_pkg;
    localparam int NUM_IN = 6;
    localparam int NIB_W  = 4;
    localparam int OP_W   = 5;
    localparam int CUM_W  = 7;
    localparam int PROD_W = 12;
    localparam int OUT_W  = 10;
    localparam int CNT_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CUM,
        ST_EQ,
        ST_EQ2,   // only reached when the equation stage is split in two
        ST_OUT
    } state_t;

    typedef logic signed [OP_W-1:0] op_t;

    // Nibble to 5-bit signed: sign-extend in signed mode, zero-extend otherwise.
    function automatic op_t encode(input logic [NIB_W-1:0] nib, input logic is_signed);
        return {is_signed & nib[NIB_W-1], nib};
    endfunction

    // Sign-extend an operand to product width.
    function automatic logic signed [PROD_W-1:0] ext_op(input op_t v);
        return {{(PROD_W-OP_W){v[OP_W-1]}}, v};
    endfunction
endpackage

// File: rtl/cc_seq_if.sv
// cc_seq_if: operand stream in, result strobe out.
//   in_valid/in_n/opt/equ : host -> core (opt/equ meaningful on nibble 0)
//   out_valid/out_n       : core -> host, out_n is 0 when out_valid is 0
// master = host side, slave = core side.
interface cc_seq_if;
    import cc_seq_pkg::*;

    logic                    in_valid;
    logic [NIB_W-1:0]        in_n;
    logic [2:0]              opt;
    logic                    equ;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_n;

    modport master (
        output in_valid, in_n, opt, equ,
        input  out_valid, out_n
    );

    modport slave (
        input  in_valid, in_n, opt, equ,
        output out_valid, out_n
    );
endinterface

// File: rtl/cc_seq_div3.sv
// cc_seq_div3: signed divide-by-3, truncating toward zero.
//   W  - input width, QW - output width (low QW bits of the quotient)
//   i_a - signed dividend, o_q - signed quotient
module cc_seq_div3 #(
    parameter int W  = 7,
    parameter int QW = 5
) (
    input  logic signed [W-1:0]  i_a,
    output logic signed [QW-1:0] o_q
);
    localparam logic signed [W-1:0] THREE = W'(3);

    // Signed '/' truncates toward zero, which is exactly the rounding wanted.
    assign o_q = QW'(i_a / THREE);
endmodule

// File: rtl/cc_seq.sv
// cc_seq: serial-input compute core. Six nibbles arrive one per accepted
// in_valid, are insertion-sorted as they arrive, then a 5-cycle cumulate
// pass and an equation stage produce one signed 10-bit result strobed for
// one cycle.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - cc_seq_if.slave (operand stream in, result out)
// Optional build macro CC_SEQ_PIPE_EQ_EN: registers the equation product and
// performs divide/abs one cycle later (one extra cycle of latency).
module cc_seq
    import cc_seq_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    cc_seq_if.slave  bus
);
    state_t                  r_state, w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        r_idx;
    logic [2:0]              r_opt;
    logic                    r_equ;
    op_t                     r_s [NUM_IN];
    op_t                     r_c [NUM_IN];
    logic signed [OUT_W-1:0] r_res;
    logic                    r_out_valid;
    logic signed [OUT_W-1:0] r_out_n;
`ifdef CC_SEQ_PIPE_EQ_EN
    logic signed [PROD_W-1:0] r_prod;
`endif

    // ---------------- insertion sort of the incoming operand ----------------
    logic        w_accept, w_sign, w_desc;
    op_t         w_new;
    logic [NUM_IN-1:0] w_before;
    op_t         w_s_ins [NUM_IN];

    assign w_accept = bus.in_valid && (r_state == ST_IDLE || r_state == ST_LOAD);
    // On nibble 0 the mode bits are not yet latched, so take them from the bus.
    assign w_sign   = (r_state == ST_IDLE) ? bus.opt[0] : r_opt[0];
    assign w_desc   = (r_state == ST_IDLE) ? bus.opt[1] : r_opt[1];
    assign w_new    = encode(bus.in_n, w_sign);

    // w_before[k]: entry k stays in place (it precedes the new value). Using
    // <= / >= places ties after existing equals, preserving arrival order.
    // Because the array is kept sorted, w_before is always a prefix.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_sort
            assign w_before[gi] = (CNT_W'(gi) < r_cnt) &&
                                  (w_desc ? (r_s[gi] >= w_new) : (r_s[gi] <= w_new));
            if (gi == 0) begin : g_first
                assign w_s_ins[gi] = w_before[gi] ? r_s[gi] : w_new;
            end else begin : g_rest
                assign w_s_ins[gi] = w_before[gi]   ? r_s[gi] :
                                     w_before[gi-1] ? w_new   : r_s[gi-1];
            end
        end
    endgenerate

    // ---------------- cumulate step for index r_idx ----------------
    op_t                     w_c_prev, w_s_cur, w_cum_q, w_c_new;
    logic signed [CUM_W-1:0] w_cum_in;

    assign w_c_prev = r_c[r_idx - CNT_W'(1)];
    assign w_s_cur  = r_s[r_idx];
    assign w_cum_in = {w_c_prev[OP_W-1], w_c_prev, 1'b0} + {{2{w_s_cur[OP_W-1]}}, w_s_cur};

    cc_seq_div3 #(.W(CUM_W), .QW(OP_W)) u_div_cum (
        .i_a (w_cum_in),
        .o_q (w_cum_q)
    );

    assign w_c_new = r_opt[2] ? w_cum_q : (w_s_cur - r_s[0]);

    // ---------------- equation ----------------
    logic signed [PROD_W-1:0] w_sum, w_diff, w_prod0, w_prod1, w_prod_sel, w_eq_in;
    logic signed [OUT_W-1:0]  w_eq_q, w_abs, w_res;

    assign w_sum      = ext_op(r_c[3]) + (ext_op(r_c[4]) <<< 2);
    assign w_prod0    = w_sum * ext_op(r_c[5]);
    assign w_diff     = ext_op(r_c[1]) - ext_op(r_c[0]);
    assign w_prod1    = ext_op(r_c[5]) * w_diff;
    assign w_prod_sel = r_equ ? w_prod1 : w_prod0;

`ifdef CC_SEQ_PIPE_EQ_EN
    assign w_eq_in = r_prod;
`else
    assign w_eq_in = w_prod_sel;
`endif

    cc_seq_div3 #(.W(PROD_W), .QW(OUT_W)) u_div_eq (
        .i_a (w_eq_in),
        .o_q (w_eq_q)
    );

    // Only the low 10 bits survive, so negate just those.
    assign w_abs = w_eq_in[PROD_W-1] ? -w_eq_in[OUT_W-1:0] : w_eq_in[OUT_W-1:0];
    assign w_res = r_equ ? w_abs : w_eq_q;

    // ---------------- FSM ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid) w_state_next = ST_LOAD;
            ST_LOAD: if (bus.in_valid && r_cnt == CNT_W'(NUM_IN - 1)) w_state_next = ST_CUM;
            ST_CUM:  if (r_idx == CNT_W'(NUM_IN - 1)) w_state_next = ST_EQ;
`ifdef CC_SEQ_PIPE_EQ_EN
            ST_EQ:   w_state_next = ST_EQ2;
`else
            ST_EQ:   w_state_next = ST_OUT;
`endif
            ST_EQ2:  w_state_next = ST_OUT;
            ST_OUT:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_opt       <= '0;
            r_equ       <= 1'b0;
            r_res       <= '0;
            r_out_valid <= 1'b0;
            r_out_n     <= '0;
            for (int k = 0; k < NUM_IN; k++) begin
                r_s[k] <= '0;
                r_c[k] <= '0;
            end
`ifdef CC_SEQ_PIPE_EQ_EN
            r_prod      <= '0;
`endif
        end else begin
            if (w_accept) begin
                for (int k = 0; k < NUM_IN; k++) r_s[k] <= w_s_ins[k];
                if (r_state == ST_IDLE) begin
                    r_opt <= bus.opt;
                    r_equ <= bus.equ;
                    r_cnt <= CNT_W'(1);
                end else if (r_cnt == CNT_W'(NUM_IN - 1)) begin
                    // Last operand: seed c0 from the final sorted head.
                    r_cnt  <= '0;
                    r_idx  <= CNT_W'(1);
                    r_c[0] <= r_opt[2] ? w_s_ins[0] : '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            if (r_state == ST_CUM) begin
                r_c[r_idx] <= w_c_new;
                r_idx      <= r_idx + CNT_W'(1);
            end

`ifdef CC_SEQ_PIPE_EQ_EN
            if (r_state == ST_EQ)  r_prod <= w_prod_sel;
            if (r_state == ST_EQ2) r_res  <= w_res;
`else
            if (r_state == ST_EQ)  r_res  <= w_res;
`endif

            r_out_valid <= (r_state == ST_OUT);
            r_out_n     <= (r_state == ST_OUT) ? r_res : '0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_n     = r_out_n;
endmodule

// File: tb/tb_cc_seq.sv
module tb_cc_seq;
    import cc_seq_pkg::*;

`ifdef CC_SEQ_PIPE_EQ_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 7;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cc_seq_if bus();

    cc_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int due;
        int val;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   results = 0;
    int   last_out = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic int wrap(input int x, input int w);
        int t;
        t = x & ((1 << w) - 1);
        if (t >= (1 << (w - 1))) t = t - (1 << w);
        return t;
    endfunction

    function automatic int model(input logic [3:0] nb [6], input logic [2:0] o, input logic e);
        int v[6];
        int c[6];
        int t, j, p, d;
        for (int i = 0; i < 6; i++)
            v[i] = (o[0] && nb[i][3]) ? int'(nb[i]) - 16 : int'(nb[i]);
        // stable insertion sort
        for (int i = 1; i < 6; i++) begin
            t = v[i];
            j = i - 1;
            while (j >= 0 && (o[1] ? (v[j] < t) : (v[j] > t))) begin
                v[j + 1] = v[j];
                j = j - 1;
            end
            v[j + 1] = t;
        end
        c[0] = o[2] ? v[0] : 0;
        for (int i = 1; i < 6; i++)
            c[i] = o[2] ? wrap((2 * c[i-1] + v[i]) / 3, 5) : wrap(v[i] - v[0], 5);
        if (!e) begin
            p = wrap((c[3] + 4 * c[4]) * c[5], 12);
            return wrap(p / 3, 10);
        end
        d = wrap(c[1] - c[0], 6);
        p = wrap(c[5] * d, 12);
        if (p < 0) p = -p;
        return wrap(p, 10);
    endfunction

    // ---------------- output compare, every cycle ----------------
    always @(negedge clk) begin
        bit exp_v;
        int exp_n;
        exp_v = (q.size() > 0) && (q[0].due == cyc);
        exp_n = exp_v ? q[0].val : 0;
        checks++;
        if (bus.out_valid !== exp_v || int'(bus.out_n) != exp_n) begin
            errors++;
            $display("FAIL out_cmp cycle %0d: got valid=%0b out_n=%0d, want valid=%0b out_n=%0d",
                     cyc, bus.out_valid, bus.out_n, exp_v, exp_n);
        end
        if (bus.out_valid === 1'b1) begin
            results++;
            last_out = int'(bus.out_n);
            $display("RESULT cycle %0d out_n %0d", cyc, bus.out_n);
        end
        if (exp_v) void'(q.pop_front());
    end

    // ---------------- driver tasks ----------------
    task automatic send_pkt(input logic [3:0] nb [6], input logic [2:0] o, input logic e,
                            input int gap_pos, input int gap_len, input bit junk);
        int m;
        m = model(nb, o, e);
        $display("PKT opt=%03b equ=%0b nib=%h %h %h %h %h %h expect %0d",
                 o, e, nb[0], nb[1], nb[2], nb[3], nb[4], nb[5], m);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_n     = nb[i];
            bus.opt      = (i == 0) ? o : 3'($urandom);
            bus.equ      = (i == 0) ? e : 1'($urandom);
            if (i == 5) q.push_back('{due: cyc + 1 + LAT, val: m});
            if (i == gap_pos && i != 5) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                    bus.in_n     = 4'($urandom);
                end
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (junk) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                bus.in_valid = 1'($urandom);
                bus.in_n     = 4'($urandom);
                bus.opt      = 3'($urandom);
                bus.equ      = 1'($urandom);
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_result();
        int start;
        bit seen;
        start = results;
        seen  = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (results > start) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL result_timeout cycle %0d: got no out_valid, want one within 40 cycles", cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic run_directed(input string name, input logic [3:0] nb [6], input logic [2:0] o,
                                input logic e, input int gap_pos, input int gap_len,
                                input bit junk, input int lit);
        checks++;
        if (model(nb, o, e) != lit) begin
            errors++;
            $display("FAIL model_%s: got %0d, want %0d", name, model(nb, o, e), lit);
        end
        send_pkt(nb, o, e, gap_pos, gap_len, junk);
        wait_result();
        checks++;
        if (last_out != lit) begin
            errors++;
            $display("FAIL dut_%s: got %0d, want %0d", name, last_out, lit);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] pi   [6] = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9};
        logic [3:0] sg   [6] = '{4'hF, 4'h8, 4'h7, 4'h0, 4'h2, 4'h3};
        logic [3:0] six  [6] = '{4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6};
        logic [3:0] trz  [6] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'hC, 4'h7};
        logic [3:0] rnd  [6];
        int res_before;

        bus.in_valid = 1'b0;
        bus.in_n     = '0;
        bus.opt      = '0;
        bus.equ      = 1'b0;

        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_n !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%0b out_n=%0d, want valid=0 out_n=0",
                     bus.out_valid, bus.out_n);
        end
        #2;
        rst_n = 1'b1;

        run_directed("uns_asc_diff",  pi,  3'b000, 1'b0, 9, 0, 0, 50);
        run_directed("uns_desc_diff", pi,  3'b010, 1'b0, 9, 0, 0, 101);
        run_directed("sgn_asc_equ1",  sg,  3'b001, 1'b1, 9, 0, 0, 105);
        run_directed("uns_cum",       six, 3'b100, 1'b0, 9, 0, 0, 60);
        run_directed("sgn_cum_trunc", trz, 3'b101, 1'b1, 9, 0, 0, 4);

        // Reset after 3 nibbles: nothing must come out.
        res_before = results;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_n     = pi[i];
            bus.opt      = 3'b000;
            bus.equ      = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        do_reset();
        repeat (12) @(negedge clk);
        checks++;
        if (results != res_before) begin
            errors++;
            $display("FAIL reset_mid_packet: got %0d results, want %0d", results, res_before);
        end

        // Replay with a 2-cycle gap after nibble 2 and junk pulses during CUM.
        run_directed("gap_replay", pi, 3'b000, 1'b0, 1, 2, 1, 50);

        // Reset during compute: result must be dropped.
        res_before = results;
        send_pkt(pi, 3'b010, 1'b0, 9, 0, 0);
        repeat (2) @(negedge clk);
        do_reset();
        repeat (15) @(negedge clk);
        checks++;
        if (results != res_before) begin
            errors++;
            $display("FAIL reset_mid_compute: got %0d results, want %0d", results, res_before);
        end

        // Randomised packets checked by the per-cycle compare.
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 6; i++) rnd[i] = 4'($urandom);
            send_pkt(rnd, 3'($urandom), 1'($urandom),
                     $urandom_range(0, 5), $urandom_range(0, 2), 1'($urandom));
            wait_result();
        end

        repeat (12) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_results: got %0d outstanding, want 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
